md_unit_ctrl: RTL and testbench

Sequencer for the shared multiply/divide resource and HI/LO registers of the 5-stage MIPS pipeline.
- Accepts one MULT/MULTU/DIV/DIVU per issue from the E stage.
- Models fixed multi-cycle latency with a busy counter and serves MFHI/MFLO/MTHI/MTLO.
- Generates the stall request that freezes D while the unit is occupied.
- Sits beside the E-stage ALU; driven by the hazard unit.

---
 rtl/md_unit_ctrl.sv | 179 +++++++++++++++++
 tb/tb_md_unit_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit_ctrl.sv
// rtl/md_unit_ctrl.sv - multiply/divide sequencer with HI/LO registers
//
// Purpose: accepts MULT/MULTU/DIV/DIVU from the E stage, holds the unit busy
// for a fixed latency, then commits the result to HI/LO. Also serves
// MFHI/MFLO (combinational read) and MTHI/MTLO (direct write), and raises the
// stall request that freezes D while the unit is occupied.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   start, op[3:0]      E-stage op valid and code (0 NONE, 1 MULT, 2 MULTU,
//                       3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO)
//   a[31:0], b[31:0]    rs / rt operands
//   d_is_md             D-stage instruction is a mult/div/HI/LO op
//   cancel              (only with MDU_CANCEL_EN) abort the running op
//   busy                multiply/divide in progress
//   hi[31:0], lo[31:0]  HI / LO registers
//   rdata[31:0]         HI for MFHI, LO for MFLO, else 0
//   stall_req           freeze D while the unit is or is about to be busy
//
// Optional feature macro: MDU_CANCEL_EN adds the cancel input.

module md_unit_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_is_md,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata,
  output logic        stall_req
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [31:0] opa, opa_n;
  logic [31:0] opb, opb_n;
  logic        op_signed, op_signed_n;
  logic [31:0] hi_r, hi_n;
  logic [31:0] lo_r, lo_n;
  logic        cancel_in;

`ifdef MDU_CANCEL_EN
  assign cancel_in = cancel;
`else
  assign cancel_in = 1'b0;
`endif

  // Multiply: extend both operands to 64 bits according to signedness; the
  // low 64 bits of the product are then correct for both MULT and MULTU.
  logic [63:0] mul_x, mul_y, prod;
  assign mul_x = op_signed ? {{32{opa[31]}}, opa} : {32'b0, opa};
  assign mul_y = op_signed ? {{32{opb[31]}}, opb} : {32'b0, opb};
  assign prod  = mul_x * mul_y;

  // Divide on magnitudes, then restore signs: quotient negative when signs
  // differ, remainder follows the dividend. 0x80000000 / -1 falls out as
  // quotient 0x80000000, remainder 0 without a signed-overflow case.
  logic        a_neg, b_neg;
  logic [31:0] ua, ub, uq, ur, quo, rem;
  assign a_neg = op_signed & opa[31];
  assign b_neg = op_signed & opb[31];
  assign ua    = a_neg ? -opa : opa;
  assign ub    = b_neg ? -opb : opb;
  assign uq    = ua / ub;
  assign ur    = ua % ub;
  assign quo   = (a_neg ^ b_neg) ? -uq : uq;
  assign rem   = a_neg ? -ur : ur;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      opa       <= '0;
      opb       <= '0;
      op_signed <= 1'b0;
      hi_r      <= '0;
      lo_r      <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      opa       <= opa_n;
      opb       <= opb_n;
      op_signed <= op_signed_n;
      hi_r      <= hi_n;
      lo_r      <= lo_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    opa_n       = opa;
    opb_n       = opb;
    op_signed_n = op_signed;
    hi_n        = hi_r;
    lo_n        = lo_r;
    case (state)
      S_IDLE: begin
        // A cancel on the same edge drops whatever start is presented.
        if (start && !cancel_in) begin
          case (op)
            4'd1, 4'd2: begin
              opa_n       = a;
              opb_n       = b;
              op_signed_n = (op == 4'd1);
              cnt_n       = 16'(MUL_LAT);
              state_n     = S_MUL;
            end
            4'd3, 4'd4: begin
              opa_n       = a;
              opb_n       = b;
              op_signed_n = (op == 4'd3);
              cnt_n       = 16'(DIV_LAT);
              state_n     = S_DIV;
            end
            4'd7:    hi_n = a;
            4'd8:    lo_n = a;
            default: ;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        // Starts are ignored here; the hazard unit holds them off via stall_req.
        if (cancel_in) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - 16'd1;
          if (cnt == 16'd1) begin
            state_n = S_IDLE;
            if (state == S_MUL) begin
              hi_n = prod[63:32];
              lo_n = prod[31:0];
            end else if (opb != 32'd0) begin
              // Divide by zero leaves HI/LO untouched.
              hi_n = rem;
              lo_n = quo;
            end
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign busy = (state != S_IDLE);
  assign hi   = hi_r;
  assign lo   = lo_r;

  always_comb begin
    rdata = 32'd0;
    if (op == 4'd5)      rdata = hi_r;
    else if (op == 4'd6) rdata = lo_r;
  end

  // Also stall on the issue cycle itself so the D-stage op cannot slip into E
  // while the unit is being claimed.
  assign stall_req = d_is_md & (busy | (start & (op >= 4'd1) & (op <= 4'd4)));

endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb/tb_md_unit_ctrl.sv - self-checking bench for md_unit_ctrl
module tb_md_unit_ctrl;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        d_is_md;
  logic        cancel;
  logic        busy;
  logic [31:0] hi, lo, rdata;
  logic        stall_req;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining busy cycles, pending result, HI/LO.
  int          m_left;
  bit          m_apply;
  logic [63:0] m_res;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  md_unit_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .d_is_md   (d_is_md),
`ifdef MDU_CANCEL_EN
    .cancel    (cancel),
`endif
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .rdata     (rdata),
    .stall_req (stall_req)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {hi, lo} for ops 1..4 from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = $signed(x);
    sy = $signed(y);
    res = '0;
    case (o)
      4'd1: res = 64'(sx * sy);
      4'd2: res = 64'(x) * 64'(y);
      4'd3: begin
        q = sx / sy;
        r = sx % sy;
        res = {r[31:0], q[31:0]};
      end
      4'd4: res = {x % y, x / y};
      default: res = '0;
    endcase
    return res;
  endfunction

  task automatic model_reset();
    m_left  = 0;
    m_apply = 0;
    m_res   = '0;
    m_hi    = '0;
    m_lo    = '0;
  endtask

  task automatic model_edge();
    bit c;
`ifdef MDU_CANCEL_EN
    c = cancel;
`else
    c = 0;
`endif
    if (m_left > 0) begin
      if (c) m_left = 0;
      else begin
        m_left--;
        if (m_left == 0 && m_apply) {m_hi, m_lo} = m_res;
      end
    end else if (start && !c) begin
      if (op >= 4'd1 && op <= 4'd4) begin
        m_left  = (op <= 4'd2) ? MUL_LAT : DIV_LAT;
        m_apply = (op <= 4'd2) || (b != 0);
        m_res   = m_apply ? ref_result(op, a, b) : '0;
      end else if (op == 4'd7) m_hi = a;
      else if (op == 4'd8) m_lo = a;
    end
  endtask

  // Inputs are set at the falling edge; compare, take the rising edge, update model.
  task automatic step();
    logic [31:0] exp_rd;
    bit exp_stall;
    #1;
    exp_rd    = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
    exp_stall = d_is_md && ((m_left > 0) || (start && op >= 4'd1 && op <= 4'd4));
    check("busy", 32'(busy), 32'(m_left > 0));
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    check("rdata", rdata, exp_rd);
    check("stall_req", 32'(stall_req), 32'(exp_stall));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_in();
    start   = 1'b0;
    op      = 4'd0;
    a       = $urandom;
    b       = $urandom;
    d_is_md = 1'b0;
    cancel  = 1'b0;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    step();
    idle_in();
  endtask

  task automatic run_md(input string tag, input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int lat,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int nb;
    issue(o, x, y);
    nb = 0;
    for (int i = 0; i < lat + 3; i++) begin
      if (busy) nb++;
      step();
    end
    check({tag, "_busy_cycles"}, 32'(nb), 32'(lat));
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom % 8);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nb;
    reset = 1'b0;
    idle_in();
    model_reset();

    // Asynchronous reset before any clock edge.
    #3 reset = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_md("mult",  4'd1, 32'hFFFF_FFFF, 32'd2, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_md("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, MUL_LAT, 32'h0000_0001, 32'hFFFF_FFFE);
    run_md("div",   4'd3, 32'hFFFF_FFF9, 32'd2, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // Divide by zero with a MULT presented during busy.
    issue(4'd8, 32'h1234_5678, 32'd0);
    issue(4'd4, 32'd7, 32'd0);
    nb = 0;
    for (int i = 0; i < DIV_LAT + 3; i++) begin
      if (i == 0) begin
        start = 1'b1;
        op    = 4'd1;
        a     = 32'hFFFF_FFFF;
        b     = 32'd2;
      end else idle_in();
      if (busy) nb++;
      step();
    end
    check("div0_busy_cycles", 32'(nb), 32'(DIV_LAT));
    check("div0_lo", lo, 32'h1234_5678);
    check("div0_hi", hi, 32'hFFFF_FFFF);

    // Stall and MFHI read across a MULT of -3 * 5.
    issue(4'd1, 32'hFFFF_FFFD, 32'd5);
    for (int i = 0; i < MUL_LAT; i++) begin
      d_is_md = 1'b1;
      op      = 4'd5;
      #1;
      check("stall_busy", 32'(stall_req), 32'd1);
      check("rd_old_hi", rdata, 32'hFFFF_FFFF);
      step();
    end
    d_is_md = 1'b1;
    op      = 4'd6;
    #1;
    check("stall_after", 32'(stall_req), 32'd0);
    check("rd_new_lo", rdata, 32'hFFFF_FFF1);
    step();
    idle_in();

    run_md("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'h0, 32'h8000_0000);

    // Back-to-back issue right as busy falls.
    issue(4'd2, 32'd6, 32'd7);
    for (int i = 0; i < MUL_LAT; i++) step();
    run_md("b2b", 4'd4, 32'd100, 32'd7, DIV_LAT, 32'd2, 32'd14);

    // Reset in the middle of a divide.
    issue(4'd3, 32'd100, 32'd7);
    step();
    step();
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      start   = ($urandom % 3) == 0;
      op      = ($urandom % 4 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
      a       = pick();
      b       = pick();
      d_is_md = 1'($urandom);
`ifdef MDU_CANCEL_EN
      cancel  = ($urandom % 12) == 0;
`else
      cancel  = 1'b0;
`endif
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
